typed_regfile: RTL



---
 rtl/typed_regfile_pkg.sv | 38 +++
 rtl/typed_regfile_cell.sv | 81 ++++++++
 rtl/typed_regfile.sv | 124 ++++++++++++
 3 files changed

// File: rtl/typed_regfile_pkg.sv
// Access codes and elaboration helpers shared by the typed register file and its cells.
// Helpers accept up to MAX_REGS registers of up to MAX_DATA_WIDTH bits.
package typed_regfile_pkg;

  typedef enum logic [2:0] {
    ACC_RW    = 3'd0,
    ACC_RO    = 3'd1,
    ACC_WO    = 3'd2,
    ACC_RC    = 3'd3,
    ACC_W1C   = 3'd4,
    ACC_W1S   = 3'd5,
    ACC_WONCE = 3'd6
  } access_e;

  localparam int ACC_W          = 3;
  localparam int MAX_REGS       = 256;
  localparam int MAX_DATA_WIDTH = 64;
  localparam int TYPES_VEC_W    = MAX_REGS * ACC_W;
  localparam int RESET_VEC_W    = MAX_REGS * MAX_DATA_WIDTH;

  // Unassigned code 7 is treated as read-only so a stray code can never open a register.
  function automatic access_e normAccess(input logic [2:0] code);
    access_e acc;
    if (code > 3'd6) acc = ACC_RO;
    else             acc = access_e'(code);
    return acc;
  endfunction

  function automatic access_e getAccess(input logic [TYPES_VEC_W-1:0] types, input int idx);
    return normAccess(types[idx*ACC_W +: ACC_W]);
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] getResetValue(
    input logic [RESET_VEC_W-1:0] values, input int idx, input int width);
    return MAX_DATA_WIDTH'(values >> (idx * width));
  endfunction

endpackage

// File: rtl/typed_regfile_cell.sv
// One typed register plus its write-once lock flag.
// Update order within a cycle: read-clear, then software write, then hardware set.
module typed_regfile_cell
  import typed_regfile_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter access_e               ACCESS      = ACC_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_hit_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_clr_i,
  input  logic                    hw_wr_en_i,
  input  logic [DATA_WIDTH-1:0]   hw_wr_data_i,
  input  logic [DATA_WIDTH-1:0]   hw_set_i,
  output logic [DATA_WIDTH-1:0]   value_o,
  output logic                    locked_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  lock_q, lock_d;
  logic [DATA_WIDTH-1:0] byteMask;
  logic [DATA_WIDTH-1:0] wrBits;

  always_comb begin
    byteMask = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      byteMask[b*8 +: 8] = {8{wr_be_i[b]}};
    end
  end

  assign wrBits = wr_data_i & byteMask;

  always_comb begin
    value_d = value_q;
    lock_d  = lock_q;
    if (rd_clr_i && (ACCESS == ACC_RC)) begin
      value_d = '0;
    end
    if (wr_hit_i) begin
      case (ACCESS)
        ACC_RW, ACC_RC, ACC_WO: value_d = (value_d & ~byteMask) | wrBits;
        ACC_W1C:                value_d = value_d & ~wrBits;
        ACC_W1S:                value_d = value_d | wrBits;
        // The lock closes on any accepted write, even one with no bytes enabled.
        ACC_WONCE: begin
          if (!lock_q) begin
            value_d = (value_d & ~byteMask) | wrBits;
            lock_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (hw_wr_en_i && (ACCESS == ACC_RO)) begin
      value_d = hw_wr_data_i;
    end
    if ((ACCESS == ACC_RC) || (ACCESS == ACC_W1C) || (ACCESS == ACC_W1S)) begin
      value_d = value_d | hw_set_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= RESET_VALUE;
      lock_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      lock_q  <= lock_d;
    end
  end

  assign value_o  = value_q;
  assign locked_o = lock_q;

endmodule

// File: rtl/typed_regfile.sv
// Parametrised multi-port CSR file: address decode, registered read ports, error pulses
// and one typed cell per register.
module typed_regfile
  import typed_regfile_pkg::*;
#(
  parameter int                               NUM_REGS     = 16,
  parameter int                               DATA_WIDTH   = 32,
  parameter int                               ADDR_WIDTH   = 8,
  parameter int                               NUM_RD_PORTS = 2,
  parameter logic [NUM_REGS*3-1:0]            ACCESS_TYPES = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               wr_en_i,
  input  logic [ADDR_WIDTH-1:0]              wr_addr_i,
  input  logic [DATA_WIDTH-1:0]              wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]            wr_be_i,
  output logic                               wr_err_o,
  input  logic [NUM_RD_PORTS-1:0]            rd_en_i,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]            rd_valid_o,
  output logic [NUM_RD_PORTS-1:0]            rd_err_o,
  input  logic [NUM_REGS-1:0]                hw_wr_en_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]     hw_wr_data_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]     hw_set_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0]     reg_q_o
);

  localparam logic [TYPES_VEC_W-1:0] TYPES_EXT  = TYPES_VEC_W'(ACCESS_TYPES);
  localparam logic [RESET_VEC_W-1:0] RESETS_EXT = RESET_VEC_W'(RESET_VALUES);

  logic [DATA_WIDTH-1:0] regValue [NUM_REGS];
  logic [NUM_REGS-1:0]   isRo, isWo, isRc, isWonce, locked;
  logic [NUM_REGS-1:0]   wrHit, rdClr;
  logic                  wrAddrValid;
  logic                  wrErr_q, wrErr_d;

  logic [ADDR_WIDTH-1:0] rdAddr   [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0] rdData_q [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0] rdData_d [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rdValid_q, rdErr_q, rdErr_d;

  assign wrAddrValid = (32'(wr_addr_i) < 32'(NUM_REGS));

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
    localparam access_e               ACC = getAccess(TYPES_EXT, gi);
    localparam logic [DATA_WIDTH-1:0] RST = DATA_WIDTH'(getResetValue(RESETS_EXT, gi, DATA_WIDTH));

    assign isRo[gi]    = (ACC == ACC_RO);
    assign isWo[gi]    = (ACC == ACC_WO);
    assign isRc[gi]    = (ACC == ACC_RC);
    assign isWonce[gi] = (ACC == ACC_WONCE);
    assign wrHit[gi]   = wr_en_i && (wr_addr_i == ADDR_WIDTH'(gi));

    typed_regfile_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACCESS      (ACC),
      .RESET_VALUE (RST)
    ) u_cell (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_hit_i     (wrHit[gi]),
      .wr_be_i      (wr_be_i),
      .wr_data_i    (wr_data_i),
      .rd_clr_i     (rdClr[gi]),
      .hw_wr_en_i   (hw_wr_en_i[gi]),
      .hw_wr_data_i (hw_wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set_i     (hw_set_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .value_o      (regValue[gi]),
      .locked_o     (locked[gi])
    );

    assign reg_q_o[gi*DATA_WIDTH +: DATA_WIDTH] = regValue[gi];
  end

  assign wrErr_d = (wr_en_i && !wrAddrValid) || (|(wrHit & (isRo | (isWonce & locked))));

  genvar gp;
  for (gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_port
    assign rdAddr[gp] = rd_addr_i[gp*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data_o[gp*DATA_WIDTH +: DATA_WIDTH] = rdData_q[gp];
  end

  // Read data is taken from the pre-edge register contents; RC clears are merged across ports.
  always_comb begin
    rdClr = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rdData_d[p] = rdData_q[p];
      rdErr_d[p]  = 1'b0;
      if (rd_en_i[p]) begin
        rdData_d[p] = '0;
        rdErr_d[p]  = (32'(rdAddr[p]) >= 32'(NUM_REGS));
        for (int r = 0; r < NUM_REGS; r++) begin
          if (rdAddr[p] == ADDR_WIDTH'(r)) begin
            if (!isWo[r]) rdData_d[p] = regValue[r];
            if (isRc[r])  rdClr[r]    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) rdData_q[p] <= '0;
      rdValid_q <= '0;
      rdErr_q   <= '0;
      wrErr_q   <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) rdData_q[p] <= rdData_d[p];
      rdValid_q <= rd_en_i;
      rdErr_q   <= rdErr_d;
      wrErr_q   <= wrErr_d;
    end
  end

  assign rd_valid_o = rdValid_q;
  assign rd_err_o   = rdErr_q;
  assign wr_err_o   = wrErr_q;

endmodule
